// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// The latency counter width is derived from the configured read latency.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR,
        RESP,
        ERR
    } arb_state_t;

    typedef enum logic {
        REQ_IF,
        REQ_D
    } req_id_t;

    localparam logic [63:0] IF_ALIGN_MASK = 64'h3;
    localparam logic [63:0] D_ALIGN_MASK  = 64'h7;

    localparam int unsigned STARVE_W = 4;

    function automatic int unsigned lat_cnt_width(input int unsigned lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter with zero flag, used to wait out the memory read latency.
module arb_lat_counter #(
    parameter int unsigned Width = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic [Width-1:0] cnt_o,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and load/store paths onto one shared 64-bit memory,
// sequencing each access over the fixed read latency and pulsing ready on completion.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ready,
    output logic [63:0] d_rdata,
    output logic        d_err,
    output logic [63:0] mem_raddr,
    output logic [63:0] mem_waddr,
    output logic [63:0] mem_wdata,
    output logic        mem_wr,
    input  logic [63:0] mem_rdata,
    output logic        busy
);

    localparam int unsigned CntW = lat_cnt_width(MEM_LAT);
    localparam logic [CntW-1:0] LatLoad = CntW'(MEM_LAT);
    localparam logic [STARVE_W-1:0] StarveMax = STARVE_W'(STARVE_MAX);

    arb_state_t          state_q, state_d;
    req_id_t             req_q, req_d;
    logic                we_q, we_d;
    logic [63:0]         wdata_q, wdata_d;
    logic [63:0]         raddr_q, raddr_d;
    logic [63:0]         waddr_q, waddr_d;
    logic [31:0]         if_rdata_q, if_rdata_d;
    logic [63:0]         d_rdata_q, d_rdata_d;
    logic [STARVE_W-1:0] starve_q, starve_d;

    logic            cnt_load;
    logic            cnt_dec;
    logic [CntW-1:0] cnt;
    logic            cnt_zero;

    arb_lat_counter #(
        .Width (CntW)
    ) u_lat_counter (
        .clock      (clock),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (LatLoad),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    logic fetch_forced;
    assign fetch_forced = if_req && (starve_q == StarveMax);

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        raddr_d    = raddr_q;
        waddr_d    = waddr_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        starve_d   = starve_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!if_req) begin
                    starve_d = '0;
                end
                if (d_req && !fetch_forced) begin
                    req_d   = REQ_D;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    // fetch_forced is false here, so starve_q < StarveMax when if_req is high
                    if (if_req) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                    if ((d_addr & D_ALIGN_MASK) != 64'h0) begin
                        state_d = ERR;
                    end else if (d_we) begin
                        waddr_d = d_addr;
                        state_d = WR;
                    end else begin
                        raddr_d  = d_addr;
                        cnt_load = 1'b1;
                        state_d  = RD_WAIT;
                    end
                end else if (if_req) begin
                    req_d    = REQ_IF;
                    we_d     = 1'b0;
                    starve_d = '0;
                    if ((if_addr & IF_ALIGN_MASK) != 64'h0) begin
                        state_d = ERR;
                    end else begin
                        raddr_d  = if_addr;
                        cnt_load = 1'b1;
                        state_d  = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                cnt_dec = !cnt_zero;
                // Capture on the edge that takes the counter from 1 to 0.
                if ((cnt == CntW'(1)) || cnt_zero) begin
                    if (req_q == REQ_IF) begin
                        if_rdata_d = raddr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                    end else begin
                        d_rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end
            end
            WR: begin
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_q      <= REQ_IF;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            raddr_q    <= '0;
            waddr_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            raddr_q    <= raddr_d;
            waddr_q    <= waddr_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            starve_q   <= starve_d;
        end
    end

    logic done;
    assign done = (state_q == RESP) || (state_q == ERR);

    assign busy      = (state_q != IDLE);
    assign mem_wr    = (state_q == WR) && we_q;
    assign mem_raddr = raddr_q;
    assign mem_waddr = waddr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ready  = done && (req_q == REQ_IF);
    assign d_ready   = done && (req_q == REQ_D);
    assign if_err    = (state_q == ERR) && (req_q == REQ_IF);
    assign d_err     = (state_q == ERR) && (req_q == REQ_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one MEM_LAT=1 instance for functional checks plus seven
// fetch-only instances sweeping MEM_LAT 1..7 (index 3 also exercises mid-read reset).
module tb_mem_port_arbiter;

    logic clock;
    logic reset;
    logic sw_reset;

    int n_checks;
    int n_errors;

    // Main instance signals
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_ready;
    logic [63:0] d_rdata;
    logic        d_err;
    logic [63:0] mem_raddr;
    logic [63:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic        mem_wr;
    logic [63:0] mem_rdata;
    logic        busy;

    logic [63:0] store_dw;

    mem_port_arbiter #(
        .MEM_LAT    (1),
        .STARVE_MAX (4)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_raddr (mem_raddr),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Memory model: dword 0x8 is preset, dword 0x40 is writable, everything else a marker
    always @(posedge clock) begin
        if (mem_wr && (mem_waddr[8:3] == 6'd8)) store_dw <= mem_wdata;
    end
    assign mem_rdata = (mem_raddr[8:3] == 6'd1) ? 64'hAAAA_BBBB_1111_2222 :
                       (mem_raddr[8:3] == 6'd8) ? store_dw : 64'h0BAD_0BAD_0BAD_0BAD;

    // Sweep instances
    logic        sw_if_req;
    logic [63:0] sw_if_addr;
    logic        sw_d_req;
    logic        sw_d_we;
    logic [63:0] sw_d_addr;
    logic [63:0] sw_d_wdata;
    logic        sw_if_ready  [7];
    logic [31:0] sw_if_rdata  [7];
    logic        sw_if_err    [7];
    logic        sw_d_ready   [7];
    logic [63:0] sw_d_rdata   [7];
    logic        sw_d_err     [7];
    logic [63:0] sw_mem_raddr [7];
    logic [63:0] sw_mem_waddr [7];
    logic [63:0] sw_mem_wdata [7];
    logic        sw_mem_wr    [7];
    logic [63:0] sw_mem_rdata [7];
    logic        sw_busy      [7];

    for (genvar k = 0; k < 7; k++) begin : g_sweep
        assign sw_mem_rdata[k] = {~sw_mem_raddr[k][31:0], sw_mem_raddr[k][31:0]};
        mem_port_arbiter #(
            .MEM_LAT    (k + 1),
            .STARVE_MAX (4)
        ) u_sw (
            .clock     (clock),
            .reset     (sw_reset),
            .if_req    (sw_if_req),
            .if_addr   (sw_if_addr),
            .if_ready  (sw_if_ready[k]),
            .if_rdata  (sw_if_rdata[k]),
            .if_err    (sw_if_err[k]),
            .d_req     (sw_d_req),
            .d_we      (sw_d_we),
            .d_addr    (sw_d_addr),
            .d_wdata   (sw_d_wdata),
            .d_ready   (sw_d_ready[k]),
            .d_rdata   (sw_d_rdata[k]),
            .d_err     (sw_d_err[k]),
            .mem_raddr (sw_mem_raddr[k]),
            .mem_waddr (sw_mem_waddr[k]),
            .mem_wdata (sw_mem_wdata[k]),
            .mem_wr    (sw_mem_wr[k]),
            .mem_rdata (sw_mem_rdata[k]),
            .busy      (sw_busy[k])
        );
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int          lat;
        int          n_grants;
        logic [9:0]  seq;
        int          lat_seen [7];
        logic [31:0] data_seen [7];
        logic        stale;

        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        sw_reset   = 1'b1;
        if_req     = 1'b0;
        if_addr    = '0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        sw_if_req  = 1'b0;
        sw_if_addr = '0;
        sw_d_req   = 1'b0;
        sw_d_we    = 1'b0;
        sw_d_addr  = '0;
        sw_d_wdata = '0;

        #2;
        reset    = 1'b0;
        sw_reset = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_if_ready", 64'(if_ready), 64'd0);
        check("rst_d_ready", 64'(d_ready), 64'd0);
        check("rst_mem_wr", 64'(mem_wr), 64'd0);
        check("rst_mem_raddr", mem_raddr, 64'd0);
        check("rst_mem_waddr", mem_waddr, 64'd0);
        check("rst_if_rdata", 64'(if_rdata), 64'd0);
        check("rst_d_rdata", d_rdata, 64'd0);
        repeat (2) tick();
        reset    = 1'b1;
        sw_reset = 1'b1;
        tick();

        // Fetch low word at 0x8
        if_addr = 64'h8;
        if_req  = 1'b1;
        tick();
        check("f8_busy", 64'(busy), 64'd1);
        check("f8_raddr", mem_raddr, 64'h8);
        check("f8_no_ready_early", 64'(if_ready), 64'd0);
        tick();
        check("f8_ready", 64'(if_ready), 64'd1);
        check("f8_err", 64'(if_err), 64'd0);
        check("f8_rdata", 64'(if_rdata), 64'h1111_2222);
        if_req = 1'b0;
        tick();
        check("f8_ready_pulse", 64'(if_ready), 64'd0);
        check("f8_idle", 64'(busy), 64'd0);
        check("f8_rdata_hold", 64'(if_rdata), 64'h1111_2222);

        // Fetch high word at 0xC
        if_addr = 64'hC;
        if_req  = 1'b1;
        tick();
        tick();
        check("fC_ready", 64'(if_ready), 64'd1);
        check("fC_rdata", 64'(if_rdata), 64'hAAAA_BBBB);
        if_req = 1'b0;
        tick();

        // Store to 0x40
        d_addr  = 64'h40;
        d_wdata = 64'hDEAD_BEEF_0123_4567;
        d_we    = 1'b1;
        d_req   = 1'b1;
        tick();
        check("st_mem_wr", 64'(mem_wr), 64'd1);
        check("st_waddr", mem_waddr, 64'h40);
        check("st_wdata", mem_wdata, 64'hDEAD_BEEF_0123_4567);
        check("st_no_ready_early", 64'(d_ready), 64'd0);
        d_req = 1'b0;
        tick();
        check("st_mem_wr_one_cycle", 64'(mem_wr), 64'd0);
        check("st_ready", 64'(d_ready), 64'd1);
        tick();
        check("st_ready_pulse", 64'(d_ready), 64'd0);

        // Load back from 0x40
        d_we  = 1'b0;
        d_req = 1'b1;
        lat   = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (d_ready) begin
                lat = c;
                break;
            end
        end
        check("ld_latency", 64'(lat), 64'd2);
        check("ld_rdata", d_rdata, 64'hDEAD_BEEF_0123_4567);
        check("ld_err", 64'(d_err), 64'd0);
        d_req = 1'b0;
        tick();

        // Misaligned store
        d_addr = 64'h43;
        d_we   = 1'b1;
        d_req  = 1'b1;
        tick();
        check("dmis_ready", 64'(d_ready), 64'd1);
        check("dmis_err", 64'(d_err), 64'd1);
        check("dmis_mem_wr", 64'(mem_wr), 64'd0);
        check("dmis_raddr", mem_raddr, 64'h40);
        check("dmis_waddr", mem_waddr, 64'h40);
        d_req = 1'b0;
        tick();
        check("dmis_ready_pulse", 64'(d_ready), 64'd0);

        // Misaligned fetch
        if_addr = 64'h2;
        if_req  = 1'b1;
        tick();
        check("fmis_ready", 64'(if_ready), 64'd1);
        check("fmis_err", 64'(if_err), 64'd1);
        check("fmis_raddr", mem_raddr, 64'h40);
        check("fmis_rdata_hold", 64'(if_rdata), 64'hAAAA_BBBB);
        if_req = 1'b0;
        tick();

        // Both requesters held high: D,D,D,D,IF repeated
        d_we     = 1'b0;
        d_addr   = 64'h40;
        if_addr  = 64'h8;
        d_req    = 1'b1;
        if_req   = 1'b1;
        seq      = '0;
        n_grants = 0;
        for (int c = 0; c < 100 && n_grants < 10; c++) begin
            tick();
            if (d_ready) begin
                seq = {seq[8:0], 1'b0};
                n_grants++;
            end else if (if_ready) begin
                seq = {seq[8:0], 1'b1};
                n_grants++;
            end
        end
        check("starve_count", 64'(n_grants), 64'd10);
        check("starve_order", 64'(seq), 64'(10'b0000100001));
        d_req  = 1'b0;
        if_req = 1'b0;
        repeat (3) tick();

        // Latency sweep MEM_LAT = 1..7
        for (int k = 0; k < 7; k++) begin
            lat_seen[k]  = 0;
            data_seen[k] = '0;
        end
        sw_if_addr = 64'h10;
        sw_if_req  = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            for (int k = 0; k < 7; k++) begin
                if (lat_seen[k] == 0 && sw_if_ready[k]) begin
                    lat_seen[k]  = c;
                    data_seen[k] = sw_if_rdata[k];
                end
            end
        end
        for (int k = 0; k < 7; k++) begin
            check($sformatf("sweep_lat%0d_latency", k + 1), 64'(lat_seen[k]), 64'(k + 2));
            check($sformatf("sweep_lat%0d_rdata", k + 1), 64'(data_seen[k]), 64'h10);
        end
        sw_if_req = 1'b0;
        repeat (20) tick();

        // Reset in the middle of RD_WAIT on the MEM_LAT=4 instance
        sw_if_addr = 64'h18;
        sw_if_req  = 1'b1;
        tick();
        tick();
        check("mid_busy_before", 64'(sw_busy[3]), 64'd1);
        #2;
        sw_reset = 1'b0;
        #1;
        check("mid_rst_busy", 64'(sw_busy[3]), 64'd0);
        check("mid_rst_ready", 64'(sw_if_ready[3]), 64'd0);
        check("mid_rst_raddr", sw_mem_raddr[3], 64'd0);
        check("mid_rst_rdata", 64'(sw_if_rdata[3]), 64'd0);
        check("mid_rst_mem_wr", 64'(sw_mem_wr[3]), 64'd0);
        sw_if_req = 1'b0;
        tick();
        sw_reset = 1'b1;
        stale    = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (sw_if_ready[3]) stale = 1'b1;
        end
        check("mid_no_stale_ready", 64'(stale), 64'd0);
        sw_if_req = 1'b1;
        lat       = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (sw_if_ready[3]) begin
                lat = c;
                break;
            end
        end
        check("mid_reissue_latency", 64'(lat), 64'd5);
        check("mid_reissue_rdata", 64'(sw_if_rdata[3]), 64'h18);
        sw_if_req = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
